mips_cpu: RTL and testbench

Single-cycle 32-bit MIPS-subset processor with a unified 512-word instruction/data RAM, a 32×32 register file and a 32-bit GPIO output. It is the top of the processor design. Every instruction fetches, decodes, executes and writes back in one clock cycle. GPIO mirrors the most recent register-file write so results can be observed externally cycle by cycle.

---
 rtl/mips_cpu_pkg.sv | 46 ++++
 rtl/mips_cpu_ram.sv | 26 ++
 rtl/mips_cpu_regfile.sv | 32 +++
 rtl/mips_cpu.sv | 150 +++++++++++++++
 tb/tb_mips_cpu.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcodes,
// R-type function codes and the internal ALU operation set.
package mips_cpu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mips_cpu_ram.sv
// Unified instruction/data RAM: combinational instruction and data reads,
// one synchronous write port. Contents are preloaded and never reset.
module mips_cpu_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic [AW-1:0] daddr,
  output logic [DW-1:0] ddata,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Store word on sw
  always_ff @(posedge clk) begin
    if (we) mem[daddr] <= wdata;
  end

  assign idata = mem[iaddr];
  assign ddata = mem[daddr];

endmodule

// File: rtl/mips_cpu_regfile.sv
// 32x32 register file: two combinational reads, one synchronous write,
// register 0 always reads zero and discards writes.
module mips_cpu_regfile #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] regs [0:(1<<AW)-1];

  // Clear all registers on reset; otherwise write any register except $0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < (1 << AW); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-subset processor top: fetch, decode, ALU, next-PC and
// GPIO mirror of the most recent register-file write.
module mips_cpu
  import mips_cpu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] gpio
);

  logic [DATA_WIDTH-1:0] pc, pc_next, pc_plus4, ir;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, imm_ext, alu_b, alu_result, mem_rdata, wr_data;
  logic [5:0]  opcode, funct;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd, wr_addr;
  logic [4:0]  shamt, sh_amt;
  logic [15:0] imm;
  logic [25:0] target;
  alu_op_e     alu_op;
  logic alu_imm, imm_zext, shift_var, reg_we, dst_rt, link;
  logic mem_we, mem_to_reg, jump, jump_reg, br_eq, br_ne, branch_taken;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign target = ir[25:0];

  mips_cpu_ram #(.AW(MEM_ADDR_WIDTH), .DW(DATA_WIDTH)) ram (
    .clk   (clk),
    .we    (mem_we && reset),   // no stores while held in reset
    .iaddr (pc[MEM_ADDR_WIDTH+1:2]),
    .idata (ir),
    .daddr (alu_result[MEM_ADDR_WIDTH+1:2]),
    .ddata (mem_rdata),
    .wdata (rt_val)
  );

  mips_cpu_regfile #(.AW(REG_ADDR_WIDTH), .DW(DATA_WIDTH)) regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .rdata_a (rs_val),
    .raddr_b (rt),
    .rdata_b (rt_val),
    .we      (reg_we),
    .waddr   (wr_addr),
    .wdata   (wr_data)
  );

  // Decode opcode/funct into datapath controls; unknown encodings stay NOPs
  always_comb begin
    alu_op = ALU_ADD; alu_imm = 1'b0; imm_zext = 1'b0; shift_var = 1'b0;
    reg_we = 1'b0; dst_rt = 1'b0; link = 1'b0; mem_we = 1'b0; mem_to_reg = 1'b0;
    jump = 1'b0; jump_reg = 1'b0; br_eq = 1'b0; br_ne = 1'b0;
    case (opcode)
      OP_R: begin
        reg_we = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLL:  alu_op = ALU_SLL;
          F_SRL:  alu_op = ALU_SRL;
          F_SRA:  alu_op = ALU_SRA;
          F_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
          F_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
          F_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
          F_JR:   begin reg_we = 1'b0; jump_reg = 1'b1; end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_imm = 1'b1; reg_we = 1'b1; dst_rt = 1'b1; end
      OP_SLTI:  begin alu_op = ALU_SLT;  alu_imm = 1'b1; reg_we = 1'b1; dst_rt = 1'b1; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_imm = 1'b1; reg_we = 1'b1; dst_rt = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND; alu_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; dst_rt = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;  alu_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; dst_rt = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR; alu_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; dst_rt = 1'b1; end
      OP_LUI:   begin alu_op = ALU_LUI; reg_we = 1'b1; dst_rt = 1'b1; end
      OP_LW:    begin alu_imm = 1'b1; reg_we = 1'b1; dst_rt = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:    begin alu_imm = 1'b1; mem_we = 1'b1; end
      OP_BEQ:   br_eq = 1'b1;
      OP_BNE:   br_ne = 1'b1;
      OP_J:     jump = 1'b1;
      OP_JAL:   begin jump = 1'b1; link = 1'b1; reg_we = 1'b1; end
      default: ;
    endcase
  end

  assign imm_ext = imm_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = alu_imm ? imm_ext : rt_val;
  assign sh_amt  = shift_var ? rs_val[4:0] : shamt;

  // ALU: arithmetic wraps, shifts operate on rt
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = rs_val + alu_b;
      ALU_SUB:  alu_result = rs_val - alu_b;
      ALU_AND:  alu_result = rs_val & alu_b;
      ALU_OR:   alu_result = rs_val | alu_b;
      ALU_XOR:  alu_result = rs_val ^ alu_b;
      ALU_NOR:  alu_result = ~(rs_val | alu_b);
      ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, rs_val < alu_b};
      ALU_SLL:  alu_result = rt_val << sh_amt;
      ALU_SRL:  alu_result = rt_val >> sh_amt;
      ALU_SRA:  alu_result = $unsigned($signed(rt_val) >>> sh_amt);
      ALU_LUI:  alu_result = {imm, 16'h0000};
      default:  alu_result = '0;
    endcase
  end

  assign wr_addr      = link ? REG_ADDR_WIDTH'(31) : (dst_rt ? rt : rd);
  assign wr_data      = link ? pc_plus4 : (mem_to_reg ? mem_rdata : alu_result);
  assign pc_plus4     = pc + DATA_WIDTH'(4);
  assign branch_taken = (br_eq && (rs_val == rt_val)) || (br_ne && (rs_val != rt_val));

  // Next-PC selection: jr, j/jal, taken branch, else sequential
  always_comb begin
    pc_next = pc_plus4;
    if (jump_reg)          pc_next = rs_val;
    else if (jump)         pc_next = {pc_plus4[31:28], target, 2'b00};
    else if (branch_taken) pc_next = pc_plus4 + {imm_ext[DATA_WIDTH-3:0], 2'b00};
  end

  // Program counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_next;
  end

  // GPIO latches every register-file write, including writes aimed at $0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      gpio <= '0;
    else if (reg_we) gpio <= wr_data;
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Directed program plus a random instruction stream, checked cycle by cycle
// against an instruction-level reference interpreter.
module tb_mips_cpu;

  logic        clk;
  logic        reset;
  logic [31:0] gpio;

  mips_cpu #(.MEM_ADDR_WIDTH(9), .REG_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .gpio  (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] img    [0:511];
  logic [31:0] m_mem  [0:511];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc, m_gpio;
  logic [31:0] exp_dir [0:19];
  logic [5:0]  rfn [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // One architectural instruction of the reference machine
  task automatic model_step();
    logic [31:0] ins, a, b, se, ze, wd, npc, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic        we;
    ins = m_mem[m_pc[10:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a  = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    ea = a + se;
    we = 1'b0; wd = 32'h0; dst = rt; npc = m_pc + 32'd4;
    case (op)
      6'h00: begin
        dst = rd; we = 1'b1;
        case (fn)
          6'h20, 6'h21: wd = a + b;
          6'h22, 6'h23: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h26: wd = a ^ b;
          6'h27: wd = ~(a | b);
          6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: wd = (a < b) ? 32'd1 : 32'd0;
          6'h00: wd = b << sh;
          6'h02: wd = b >> sh;
          6'h03: wd = $unsigned($signed(b) >>> sh);
          6'h04: wd = b << a[4:0];
          6'h06: wd = b >> a[4:0];
          6'h07: wd = $unsigned($signed(b) >>> a[4:0]);
          6'h08: begin we = 1'b0; npc = a; end
          default: we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin we = 1'b1; wd = a + se; end
      6'h0A: begin we = 1'b1; wd = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin we = 1'b1; wd = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin we = 1'b1; wd = a & ze; end
      6'h0D: begin we = 1'b1; wd = a | ze; end
      6'h0E: begin we = 1'b1; wd = a ^ ze; end
      6'h0F: begin we = 1'b1; wd = {ins[15:0], 16'h0000}; end
      6'h23: begin we = 1'b1; wd = m_mem[ea[10:2]]; end
      6'h2B: m_mem[ea[10:2]] = b;
      6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
      6'h05: if (a != b) npc = m_pc + 32'd4 + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin npc = {npc[31:28], ins[25:0], 2'b00}; we = 1'b1; dst = 5'd31; wd = m_pc + 32'd4; end
      default: ;
    endcase
    if (we) begin
      m_gpio = wd;
      if (dst != 5'd0) m_regs[dst] = wd;
    end
    m_pc = npc;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_gpio = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  task automatic run_cycles(input int n, input int pass);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      $display("pass %0d cycle %0d: pc=%h gpio=%h", pass, c, dut.pc, gpio);
      check($sformatf("gpio p%0d c%0d", pass, c), gpio, m_gpio);
      check($sformatf("pc p%0d c%0d", pass, c), dut.pc, m_pc);
      if (c <= 20) check($sformatf("directed_gpio p%0d c%0d", pass, c), gpio, exp_dir[c-1]);
      if (c == 11) check("sw_mem64", dut.ram.mem[64], 32'h00000007);
      if (c == 13) check("beq_skip_pc", dut.pc, 32'h00000038);
    end
  endtask

  function automatic logic [31:0] rand_instr(input int k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] off;
    int sel;
    sel = $urandom_range(0, 9);
    rs  = 5'($urandom_range(0, 31));
    rt  = 5'($urandom_range(0, 31));
    rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    off = 16'(16'h0600 + 4 * $urandom_range(0, 127) + $urandom_range(0, 3));
    if (sel <= 3)      return enc_r(rfn[$urandom_range(0, 15)], rs, rt, rd, 5'($urandom_range(0, 31)));
    else if (sel <= 6) return enc_i(6'(8 + $urandom_range(0, 7)), rs, rd, 16'($urandom));
    else if (sel == 7) return enc_i(6'h23, 5'd0, rd, off);
    else if (sel == 8) return enc_i(6'h2B, 5'd0, rt, off);
    else if (k[0])     return {6'h3F, 26'($urandom)};
    else               return {6'h00, 20'($urandom), 6'h3F};
  endfunction

  initial begin
    int nz, mm;
    reset = 1'b0;
    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    exp_dir = '{32'hFFFFFFFF, 32'h00000001, 32'h00000006, 32'h00000007,
                32'h0000FF00, 32'hFFFFFF00, 32'hFFFFFFFF, 32'h00FFFFFF,
                32'h00FF0000, 32'h00FFF00C, 32'h00FFF00C, 32'h00000007,
                32'h00000007, 32'h00000007, 32'h00000040, 32'h00000123,
                32'h00000123, 32'h00000001, 32'h00000000, 32'h00000000};

    for (int i = 0; i < 512; i++) img[i] = 32'h0;
    img[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
    img[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'h0001);
    img[2]  = enc_i(6'h08, 5'd0, 5'd3, 16'h0006);
    img[3]  = enc_r(6'h20, 5'd3, 5'd2, 5'd4, 5'd0);
    img[4]  = enc_i(6'h0C, 5'd1, 5'd5, 16'hFF00);
    img[5]  = enc_i(6'h08, 5'd0, 5'd6, 16'hFF00);
    img[6]  = enc_r(6'h03, 5'd0, 5'd6, 5'd7, 5'd8);
    img[7]  = enc_r(6'h02, 5'd0, 5'd7, 5'd8, 5'd8);
    img[8]  = enc_i(6'h0F, 5'd0, 5'd9, 16'h00FF);
    img[9]  = enc_i(6'h0E, 5'd9, 5'd10, 16'hF00C);
    img[10] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0100);
    img[11] = enc_i(6'h23, 5'd0, 5'd11, 16'h0100);
    img[12] = enc_i(6'h04, 5'd2, 5'd2, 16'h0001);
    img[13] = enc_i(6'h08, 5'd0, 5'd20, 16'h0055);
    img[14] = enc_i(6'h05, 5'd2, 5'd2, 16'h0005);
    img[15] = enc_j(6'h03, 26'd20);
    img[16] = enc_r(6'h2A, 5'd1, 5'd2, 5'd12, 5'd0);
    img[17] = enc_r(6'h2B, 5'd1, 5'd2, 5'd12, 5'd0);
    img[18] = enc_j(6'h02, 26'd80);
    img[20] = enc_i(6'h08, 5'd0, 5'd13, 16'h0123);
    img[21] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    for (int k = 80; k < 280; k++) img[k] = rand_instr(k);
    img[280] = enc_j(6'h02, 26'd280);
    for (int k = 384; k < 512; k++) img[k] = $urandom;

    for (int i = 0; i < 512; i++) begin
      m_mem[i] = img[i];
      dut.ram.mem[i] = img[i];
    end
    model_reset();

    @(negedge clk);
    check("reset_pc", dut.pc, 32'h0);
    check("reset_gpio", gpio, 32'h0);
    reset = 1'b1;

    run_cycles(150, 1);

    // Asynchronous reset in the middle of the random stream
    #2 reset = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.regfile.regs[i] !== 32'h0) nz++;
    mm = 0;
    for (int i = 0; i < 512; i++) if (dut.ram.mem[i] !== m_mem[i]) mm++;
    $display("mid-program reset: pc=%h gpio=%h nonzero_regs=%0d ram_diffs=%0d", dut.pc, gpio, nz, mm);
    check("midreset_pc", dut.pc, 32'h0);
    check("midreset_gpio", gpio, 32'h0);
    check("midreset_regs_nonzero", 32'(nz), 32'h0);
    check("midreset_ram_diffs", 32'(mm), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("held_reset_pc", dut.pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    run_cycles(260, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
